// File: rtl/program_button_ctrl.sv
// program_button_ctrl
//   Command initiator for the alarm-programming digit counters. Synchronises and
//   debounces the raw up/down buttons, then issues one-cycle add/subtract pulses
//   with auto-repeat while a single button stays held. Conflicting presses and
//   presses made outside program mode are blocked until both buttons are released.
// Ports
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   en        program mode active; pulses only while high
//   btn_up    raw up button (asynchronous, active-high)
//   btn_down  raw down button (asynchronous, active-high)
//   add       one-cycle increment command
//   subtract  one-cycle decrement command
//   held      high while a single button is held and auto-repeat is armed/running
module program_button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD   = 100,
  parameter int unsigned CNT_WIDTH       = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_up,
  input  logic btn_down,
  output logic add,
  output logic subtract,
  output logic held
);

  localparam logic [CNT_WIDTH-1:0] DB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PER_LAST   = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    REPEAT,
    LOCK,
    WAIT_REL
  } state_t;

  // Index 0 = up, index 1 = down.
  logic [1:0]           raw;
  logic [1:0]           sync1;
  logic [1:0]           sync2;
  logic [1:0]           deb;
  logic [CNT_WIDTH-1:0] db_cnt [2];

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] timer;
  logic                 dir_up;
  logic                 add_next;
  logic                 sub_next;
  logic                 own;
  logic                 other;

  assign raw = {btn_down, btn_up};

  // Two-flop synchronisers followed by per-button debounce counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      deb   <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != CNT_MAX) begin
          db_cnt[i] <= db_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Button that started the current auto-repeat run vs. the other one.
  assign own   = dir_up ? deb[0] : deb[1];
  assign other = dir_up ? deb[1] : deb[0];

  // Next-state and pulse decision.
  always_comb begin
    state_next = state;
    add_next   = 1'b0;
    sub_next   = 1'b0;
    if (!en) begin
      state_next = (|deb) ? WAIT_REL : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (deb[0] && deb[1]) begin
            state_next = LOCK;
          end else if (deb[0] || deb[1]) begin
            add_next   = deb[0];
            sub_next   = deb[1];
            state_next = FIRST;
          end
        end
        FIRST, REPEAT: begin
          // Own release takes priority so a button swap goes through IDLE.
          if (!own) begin
            state_next = IDLE;
          end else if (other) begin
            state_next = LOCK;
          end else if (timer == ((state == FIRST) ? DELAY_LAST : PER_LAST)) begin
            add_next   = dir_up;
            sub_next   = !dir_up;
            state_next = REPEAT;
          end
        end
        LOCK, WAIT_REL: begin
          if (!(|deb)) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, timer, direction and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      dir_up   <= 1'b0;
      add      <= 1'b0;
      subtract <= 1'b0;
      held     <= 1'b0;
    end else begin
      state    <= state_next;
      add      <= add_next;
      subtract <= sub_next;
      held     <= (state == FIRST) || (state == REPEAT);
      // Timer restarts on each state change and on every repeat pulse.
      if ((state_next != state) || add_next || sub_next) begin
        timer <= '0;
      end else if (timer != CNT_MAX) begin
        timer <= timer + CNT_WIDTH'(1);
      end
      if ((state == IDLE) && (add_next || sub_next)) begin
        dir_up <= add_next;
      end
    end
  end

endmodule

// File: tb/tb_program_button_ctrl.sv
// tb_program_button_ctrl
//   Directed bench for program_button_ctrl with short timing parameters.
//   Expected pulses are queued with their cycle number when stimulus is driven
//   and compared against add/subtract on every cycle.
module tb_program_button_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic btn_up;
  logic btn_down;
  logic add;
  logic subtract;
  logic held;

  typedef struct {
    int   cyc;
    logic is_add;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;
  int   c0;
  int   c1;

  program_button_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_WIDTH      (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .add     (add),
    .subtract(subtract),
    .held    (held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic push(input int c, input logic a);
    exp_t e;
    e.cyc    = c;
    e.is_add = a;
    sb.push_back(e);
  endtask

  // One clock: count the edge, then sample outputs on the falling edge.
  task automatic tick();
    logic [1:0] exp_v;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_v = 2'b00;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_v = sb[0].is_add ? 2'b10 : 2'b01;
      void'(sb.pop_front());
    end
    check("pulse", 32'({add, subtract}), 32'(exp_v));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    en       = 1'b1;
    btn_up   = 1'b1;
    btn_down = 1'b1;

    // Reset with buttons pressed: outputs stay low during and right after reset.
    tick();
    check("rst_held", 32'(held), 32'(0));
    tick();
    check("rst_held", 32'(held), 32'(0));
    rst      = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick();
    check("post_rst_held", 32'(held), 32'(0));
    run(10);

    // Single add pulse for an 8-cycle press; held tracks FIRST with one cycle lag.
    c0 = cyc;
    btn_up = 1'b1;
    push(c0 + 7, 1'b1);
    for (int i = 1; i <= 25; i++) begin
      tick();
      check("held_single", 32'(held), 32'(i >= 8 && i <= 15));
      if (i == 8) btn_up = 1'b0;
    end
    check("sb_single", 32'(sb.size()), 32'(0));
    run(5);

    // Auto-repeat on down; release timed so the last repeat lands at cycle 32.
    c0 = cyc;
    btn_down = 1'b1;
    push(c0 + 7, 1'b0);
    for (int p = c0 + 17; p <= c0 + 28 + 6; p += 3) push(p, 1'b0);
    run_until(c0 + 28);
    btn_down = 1'b0;
    run_until(c0 + 50);
    check("sb_repeat", 32'(sb.size()), 32'(0));
    check("held_repeat_end", 32'(held), 32'(0));

    // Bounces of 3 cycles are filtered out entirely.
    for (int k = 0; k < 5; k++) begin
      btn_up = 1'b1;
      run(3);
      btn_up = 1'b0;
      run(1);
    end
    run(20);
    check("held_bounce", 32'(held), 32'(0));

    // Conflict: down joins while up repeats -> lock, then clean re-press works.
    c0 = cyc;
    btn_up = 1'b1;
    push(c0 + 7, 1'b1);
    push(c0 + 17, 1'b1);
    run_until(c0 + 12);
    btn_down = 1'b1;
    run_until(c0 + 25);
    check("held_lock", 32'(held), 32'(0));
    run_until(c0 + 40);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    run(20);
    c1 = cyc;
    btn_up = 1'b1;
    push(c1 + 7, 1'b1);
    run(8);
    btn_up = 1'b0;
    run(20);
    check("sb_lock", 32'(sb.size()), 32'(0));

    // Button held while en low: no pulse when en rises, only after re-press.
    en = 1'b0;
    c0 = cyc;
    btn_up = 1'b1;
    run_until(c0 + 20);
    en = 1'b1;
    run_until(c0 + 30);
    check("held_wait_rel", 32'(held), 32'(0));
    btn_up = 1'b0;
    run(20);
    c1 = cyc;
    btn_up = 1'b1;
    push(c1 + 7, 1'b1);
    run(8);
    btn_up = 1'b0;
    run(20);
    check("sb_en", 32'(sb.size()), 32'(0));

    // Switching buttons in one cycle: down pulse comes from IDLE one cycle later.
    c0 = cyc;
    btn_up = 1'b1;
    push(c0 + 7, 1'b1);
    run_until(c0 + 8);
    btn_up   = 1'b0;
    btn_down = 1'b1;
    push(c0 + 16, 1'b0);
    run_until(c0 + 18);
    btn_down = 1'b0;
    run(20);
    check("sb_switch", 32'(sb.size()), 32'(0));

    // Reset in the middle of auto-repeat suppresses the pending pulse.
    c0 = cyc;
    btn_down = 1'b1;
    push(c0 + 7, 1'b0);
    push(c0 + 17, 1'b0);
    push(c0 + 20, 1'b0);
    run_until(c0 + 21);
    rst      = 1'b1;
    btn_down = 1'b0;
    tick();
    check("midrst_held", 32'(held), 32'(0));
    tick();
    check("midrst_held", 32'(held), 32'(0));
    rst = 1'b0;
    tick();
    check("midrst_after_held", 32'(held), 32'(0));
    run(20);
    check("sb_midrst", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
